// File: rtl/imem_loader_if.sv
// Memory write port bundle: one store per cycle with enable, byte address,
// data and RISC-V store width. The master drives, the slave observes.
interface imem_loader_if;
  logic        wen;
  logic [31:0] wa;
  logic [31:0] wd;
  logic [2:0]  funct3;

  modport master (output wen, output wa, output wd, output funct3);
  modport slave  (input  wen, input  wa, input  wd, input  funct3);
endinterface

// File: rtl/imem_loader.sv
// Program upload sequencer: when the UART image buffer fills, hold the CPU in
// reset, stream every FIFO byte into memory as little-endian 32-bit words
// starting at BASE_ADDR, acknowledge the UART, then let the CPU run.
// Outside a load the CPU owns the memory write port.
//
// Handshake: fifo_full is a level meaning "an image is waiting". fifo_full_ack
// is a single-cycle pulse meaning "image consumed"; the UART drops fifo_full
// afterwards, and the loader does not return to IDLE until it has seen the
// level low, so one image is never loaded twice.
module imem_loader #(
  parameter int          DEPTH     = 512,
  parameter int          ADDR_W    = $clog2(DEPTH),
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_full,
  output logic              fifo_full_ack,
  output logic              fifo_addr_sel,
  output logic [ADDR_W-1:0] fifo_addr,
  input  logic [7:0]        fifo_rd,
  imem_loader_if.slave      cpu_mem,
  imem_loader_if.master     mem,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              load_done,
  output logic [2:0]        dbg_state
);

  localparam int                WORD_W    = ADDR_W - 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(DEPTH / 4 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    DRAIN   = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e            state;
  state_e            state_next;
  logic              rd_valid;   // fifo_rd carries the byte addressed last cycle
  logic [1:0]        byte_lane;  // lane of the byte currently on fifo_rd
  logic [WORD_W-1:0] word_cnt;   // index of the word being assembled
  logic [23:0]       shreg;      // lower three bytes of the word in progress
  logic              ld_wr;

  // State register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fifo_full) state_next = LOAD;
      LOAD:    if (fifo_addr == LAST_ADDR) state_next = DRAIN;
      DRAIN:   state_next = ACK;
      ACK:     state_next = RELEASE;
      RELEASE: if (!fifo_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address counter, byte capture and word counter; all restart from 0 in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_addr <= '0;
      rd_valid  <= 1'b0;
      byte_lane <= 2'd0;
      word_cnt  <= '0;
      shreg     <= 24'h0;
      load_done <= 1'b0;
    end else begin
      rd_valid  <= (state == LOAD);
      load_done <= (state == RELEASE) && !fifo_full;
      if (state == IDLE) begin
        fifo_addr <= '0;
        byte_lane <= 2'd0;
        word_cnt  <= '0;
      end else begin
        // Hold on the last address rather than wrapping inside a load.
        if (state == LOAD && fifo_addr != LAST_ADDR)
          fifo_addr <= fifo_addr + 1'b1;
        if (rd_valid) begin
          byte_lane <= byte_lane + 2'd1;
          case (byte_lane)
            2'd0:    shreg[7:0]   <= fifo_rd;
            2'd1:    shreg[15:8]  <= fifo_rd;
            2'd2:    shreg[23:16] <= fifo_rd;
            default: ;
          endcase
          if (byte_lane == 2'd3 && word_cnt != LAST_WORD)
            word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end

  // Status outputs and memory write port arbitration.
  always_comb begin
    busy          = (state != IDLE);
    fifo_addr_sel = (state == LOAD) || (state == DRAIN);
    fifo_full_ack = (state == ACK);
    cpu_reset_n   = reset_n & (state == IDLE);
    dbg_state     = state;
    // The fourth byte of a word goes straight from fifo_rd to memory.
    ld_wr         = rd_valid && (byte_lane == 2'd3);
    mem.wen       = 1'b0;
    mem.wa        = 32'h0;
    mem.wd        = 32'h0;
    mem.funct3    = 3'b000;
    if (state == IDLE) begin
      mem.wen    = cpu_mem.wen & reset_n;
      mem.wa     = cpu_mem.wa;
      mem.wd     = cpu_mem.wd;
      mem.funct3 = cpu_mem.funct3;
    end else begin
      mem.wen    = ld_wr & reset_n;
      mem.wa     = BASE_ADDR + {{(32 - ADDR_W){1'b0}}, word_cnt, 2'b00};
      mem.wd     = {fifo_rd, shreg};
      mem.funct3 = 3'b010;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: FIFO read model, scoreboard of expected word stores,
// directed scenarios for passthrough, full loads, ack handshake and abort.
module tb_imem_loader;

  localparam int DEPTH  = 512;
  localparam int ADDR_W = 9;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic              fifo_full;
  logic              fifo_full_ack;
  logic              fifo_addr_sel;
  logic [ADDR_W-1:0] fifo_addr;
  logic [7:0]        fifo_rd;
  logic              cpu_reset_n;
  logic              busy;
  logic              load_done;
  logic [2:0]        dbg_state;

  imem_loader_if cpu_if();
  imem_loader_if mem_if();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(32'h0)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .fifo_full     (fifo_full),
    .fifo_full_ack (fifo_full_ack),
    .fifo_addr_sel (fifo_addr_sel),
    .fifo_addr     (fifo_addr),
    .fifo_rd       (fifo_rd),
    .cpu_mem       (cpu_if),
    .mem           (mem_if),
    .cpu_reset_n   (cpu_reset_n),
    .busy          (busy),
    .load_done     (load_done),
    .dbg_state     (dbg_state)
  );

  // FIFO model: read data valid one cycle after the address.
  logic [7:0] img [DEPTH];
  always @(posedge clk) fifo_rd <= img[fifo_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {load-relative cycle[15:0], addr[31:0], data[31:0]}
  logic [79:0] exp_q[$];
  int load0   = 0;
  int wr_cnt  = 0;
  int ack_cnt = 0;

  always @(negedge clk) begin
    logic [79:0] e;
    if (fifo_full_ack) ack_cnt++;
    if (mem_if.wen && busy) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check("wr_extra", 64'(cyc - load0), 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_cyc",  64'(cyc - load0), 64'(e[79:64]));
        check("wr_addr", 64'(mem_if.wa), 64'(e[63:32]));
        check("wr_data", 64'(mem_if.wd), 64'(e[31:0]));
        check("wr_f3",   64'(mem_if.funct3), 64'(3'b010));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_img(input bit rnd);
    for (int i = 0; i < DEPTH; i++)
      img[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i);
  endtask

  task automatic push_words(input int n_words);
    logic [31:0] d;
    for (int w = 0; w < n_words; w++) begin
      d = {img[4*w+3], img[4*w+2], img[4*w+1], img[4*w]};
      exp_q.push_back({16'(4*w + 4), 32'(4*w), d});
    end
  endtask

  // Full load; drop_k >= 0 drops fifo_full at that LOAD cycle, otherwise
  // fifo_full stays high for hold cycles of RELEASE before falling.
  task automatic do_load(input int drop_k, input int hold);
    int rel;
    int ack_rel;
    int hold_bad;
    exp_q.delete();
    push_words(DEPTH / 4);
    wr_cnt   = 0;
    hold_bad = 0;
    ack_rel  = -1;
    @(negedge clk);
    fifo_full = 1'b1;
    load0     = cyc + 1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      rel = cyc - load0;
      if (fifo_full_ack) begin
        ack_rel = rel;
        break;
      end
      if (cpu_reset_n !== 1'b0) hold_bad++;
      if (rel == drop_k) fifo_full = 1'b0;
      cpu_if.wen    = 1'($urandom_range(0, 1));
      cpu_if.wa     = $urandom;
      cpu_if.wd     = $urandom;
      cpu_if.funct3 = 3'($urandom_range(0, 7));
    end
    cpu_if.wen = 1'b0;
    // cycle numbering counts the IDLE sampling cycle as cycle 1
    check("ack_cycle", 64'(ack_rel + 2), 64'(DEPTH + 3));
    check("cpu_held", 64'(hold_bad), 64'd0);
    @(negedge clk);
    check("rel_state", 64'(dbg_state), 64'(ST_RELEASE));
    check("ack_once", 64'(fifo_full_ack), 64'd0);
    if (drop_k < 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check("rel_hold", 64'(dbg_state), 64'(ST_RELEASE));
        check("ld_hold", 64'(load_done), 64'd0);
        check("cpu_hold_rel", 64'(cpu_reset_n), 64'd0);
      end
      fifo_full = 1'b0;
    end
    @(negedge clk);
    check("ld_pulse", 64'(load_done), 64'd1);
    check("cpu_run", 64'(cpu_reset_n), 64'd1);
    check("idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("ld_once", 64'(load_done), 64'd0);
    check("wr_count", 64'(wr_cnt), 64'(DEPTH / 4));
    check("q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int a0;
    reset_n       = 1'b0;
    fifo_full     = 1'b0;
    cpu_if.wen    = 1'b1;
    cpu_if.wa     = 32'h40;
    cpu_if.wd     = 32'h1234;
    cpu_if.funct3 = 3'b010;
    fill_img(1'b0);
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ack", 64'(fifo_full_ack), 64'd0);
    check("rst_done", 64'(load_done), 64'd0);
    check("rst_sel", 64'(fifo_addr_sel), 64'd0);
    check("rst_addr", 64'(fifo_addr), 64'd0);
    check("rst_cpu", 64'(cpu_reset_n), 64'd0);
    check("rst_wen", 64'(mem_if.wen), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    reset_n = 1'b1;

    // idle passthrough
    @(negedge clk);
    cpu_if.wen = 1'b1; cpu_if.wa = 32'h100; cpu_if.wd = 32'hDEADBEEF; cpu_if.funct3 = 3'b010;
    #1;
    check("pt_wen", 64'(mem_if.wen), 64'd1);
    check("pt_wa", 64'(mem_if.wa), 64'h100);
    check("pt_wd", 64'(mem_if.wd), 64'hDEADBEEF);
    check("pt_f3", 64'(mem_if.funct3), 64'(3'b010));
    check("pt_cpu", 64'(cpu_reset_n), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = $urandom; d = $urandom;
      cpu_if.wen = 1'(i); cpu_if.wa = a; cpu_if.wd = d; cpu_if.funct3 = 3'(i);
      #1;
      check("ptr_wen", 64'(mem_if.wen), 64'(i % 2));
      check("ptr_wa", 64'(mem_if.wa), 64'(a));
      check("ptr_wd", 64'(mem_if.wd), 64'(d));
      check("ptr_f3", 64'(mem_if.funct3), 64'(i));
    end
    cpu_if.wen = 1'b0;

    // full load with ramp image; first/last words known by construction
    fill_img(1'b0);
    check("img_w0", 64'({img[3], img[2], img[1], img[0]}), 64'h03020100);
    check("img_w127", 64'({img[511], img[510], img[509], img[508]}), 64'hFFFEFDFC);
    do_load(-1, 0);

    // fifo_full held 5 cycles after ack
    fill_img(1'b1);
    do_load(-1, 5);

    // fifo_full dropped early in LOAD
    fill_img(1'b1);
    do_load(10, 0);

    // reset at LOAD cycle 200
    fill_img(1'b1);
    exp_q.delete();
    push_words(49);
    wr_cnt = 0;
    a0     = ack_cnt;
    @(negedge clk);
    fifo_full = 1'b1;
    load0     = cyc + 1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (cyc - load0 == 199) break;
    end
    cpu_if.wen = 1'b1;
    @(posedge clk);
    #1;
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    #1;
    check("abort_cyc", 64'(cyc - load0), 64'd200);
    check("abort_state", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_cpu", 64'(cpu_reset_n), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_sel", 64'(fifo_addr_sel), 64'd0);
    check("abort_wen", 64'(mem_if.wen), 64'd0);
    repeat (2) @(negedge clk);
    reset_n    = 1'b1;
    cpu_if.wen = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_state2", 64'(dbg_state), 64'(ST_IDLE));
    check("abort_noack", 64'(ack_cnt - a0), 64'd0);
    check("abort_wr", 64'(wr_cnt), 64'd49);
    check("abort_q", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
